mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter that shares one 8-to-1 multiplexer (`mux8to1`) among eight requesters. It accepts a request vector, grants exactly one requester at a time, and drives the mux select lines to match the grant. The grant is held until the owner releases it. In the parent, `sel` connects directly to `mux8to1.S`; the mux output `Y` is valid for the owner whenever `busy` is high.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before a forced hand-off. Used only when `MUX8_ARB_TIMEOUT_EN` is defined; legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 8: request vector; bit i = requester i wants the mux.
- `gnt` out 8: one-hot grant, registered; all-zero when idle.
- `sel` out 3: binary index of the granted requester, registered; drives mux `S`.
- `busy` out 1: high when a grant is active; equals `|gnt`.
- `timeout` out 1: one-cycle pulse on a forced hand-off. Tied 0 when the macro is absent.

## Operation
- States: IDLE (no owner) and GRANT (owner = `sel`).
- Priority pointer `last` (3 bits) holds the most recently granted index. The search order is `last+1`, `last+2`, … `last+8`, all mod 8, so the current owner has the lowest priority.
- IDLE → GRANT: at an edge where `req != 0`, grant the first set bit in the search order. Update `gnt`, `sel`, `busy` and `last`.
- GRANT, hold: while `req[sel]=1` (and no timeout), outputs stay unchanged.
- GRANT, release: at an edge where `req[sel]=0`, re-arbitrate over `req` on the same edge.
  - If another request is pending, hand off directly to the next index with no idle gap.
  - If no request is pending, go to IDLE: `gnt=0`, `busy=0`, `sel` holds its last value.
- Forced hand-off (macro only): treated like a release, but the current owner's bit is masked from the search. A `timeout` pulse accompanies it.
- Requester bits other than the owner's can change freely and have no effect until the next arbitration edge.
- `gnt` is never multi-hot. `sel` always equals the encoded `gnt` while `busy=1`.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - outputs: `gnt=0`, `sel=0`, `busy=0`, `timeout=0`;
  - state: IDLE, `last=7` (the first search after reset starts at index 0), hold counter 0.

## Timing
- Grant latency: a request sampled at edge N gives a grant visible after edge N, one cycle from request assertion.
- Release latency: `req[sel]` dropped before edge N clears or transfers the grant after edge N.
- Back-to-back hand-off costs 0 idle cycles.
- The mux output `Y` is valid in the same cycle `busy` is high, since mux8to1 is combinational.
- Worst-case wait for any requester (macro on): 7×MAX_HOLD cycles.

## Configuration
- `MUX8_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD−1 and any other request bit is set, the arbiter forces a hand-off and `timeout` pulses for 1 cycle.
  - If no other request is pending, the counter clears and the owner keeps the grant with no pulse.
- `MUX8_ARB_TIMEOUT_EN` not defined: no counter is built, `timeout` is tied 0, and the owner holds the grant indefinitely.

## Structure
- Package `mux8_arb_pkg` holds:
  - `N_REQ=8` and `SEL_W=3`;
  - the state enum `arb_state_t` {ARB_IDLE, ARB_GRANT};
  - `HOLD_W=8`.
- Sub-module `rr_pick8`: a combinational rotating-priority search. Inputs are `req[7:0]`, `mask[7:0]` and `last[2:0]`; outputs are `found`, `idx[2:0]` and `onehot[7:0]`.
- mux8_rr_arbiter contains the FSM, the output registers and the hold counter. It does not instantiate mux8to1; the parent wires `sel` to the mux.

## Test plan
- Reset with `req=0x00` → `gnt=0x00`, `sel=0`, `busy=0` for 5 cycles. Assert `rst` asynchronously mid-cycle during a grant → outputs go to 0 before the next edge.
- `req=0x04` → after 1 edge `gnt=0x04`, `sel=2`, `busy=1`. Hold for 10 cycles → unchanged. Drop `req` → `gnt=0`, `busy=0`, `sel=2`.
- From reset, `req=0xFF` → grant 0. Drop bit 0 → grant 1 on the next edge with no gap. Then drop bit 1 → grant 2.
- Owner 2 with `req=0x05` → drop bit 2 → search starts at 3 and wraps to 0: `gnt=0x01`, `sel=0`.
- Macro on, MAX_HOLD=4, `req=0x03` held → `gnt=0x01` for 4 cycles, then `gnt=0x02` with a `timeout` pulse, then back to 0x01 after 4 more cycles.
- Macro on, MAX_HOLD=4, `req=0x08` held alone → grant stays 3 for 20 cycles and `timeout` stays 0.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared widths and FSM state type for the 8-way round-robin mux arbiter
package mux8_arb_pkg;
  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: rotating-priority search starting at last+1, owner last, masked bits skipped
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);
  logic [N_REQ-1:0] eff;
  logic [SEL_W-1:0] p;
  // walk from farthest to nearest so the nearest hit in search order wins
  always_comb begin
    eff = req & ~mask;
    found = 1'b0;
    idx = '0;
    p = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = last + SEL_W'(k);
      if (eff[p]) begin
        found = 1'b1;
        idx = p;
      end
    end
    onehot = found ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner select for a shared mux8to1; grant held until released
// MUX8_ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced hand-off with a timeout pulse.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);
  arb_state_t       state;
  logic [SEL_W-1:0] last, idx;
  logic [N_REQ-1:0] onehot, mask;
  logic             found, arb, force_ho;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be 2..255");
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_max;
  assign hold_max = hold_cnt == HOLD_W'(MAX_HOLD - 1);
  assign force_ho = state == ARB_GRANT && req[sel] && hold_max && |(req & ~gnt);
  // a lone owner at the limit just restarts its count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= (arb || hold_max) ? '0 : hold_cnt + 1'b1;
      timeout <= force_ho;
    end
`else
  assign force_ho = 1'b0;
  assign timeout = 1'b0;
`endif

  assign mask = force_ho ? gnt : '0;
  assign arb = state == ARB_IDLE || !req[sel] || force_ho;
  assign busy = |gnt;

  rr_pick8 u_pick (
    .req   (req),
    .mask  (mask),
    .last  (last),
    .found (found),
    .idx   (idx),
    .onehot(onehot)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB_IDLE;
      last <= SEL_W'(N_REQ - 1);
      gnt <= '0;
      sel <= '0;
    end else if (arb) begin
      state <= found ? ARB_GRANT : ARB_IDLE;
      gnt <= onehot;
      sel <= found ? idx : sel;
      last <= found ? idx : last;
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: scoreboard bench; a behavioural model queues expected outputs per edge
module tb_mux8_rr_arbiter;
  localparam int MH = 4;
`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy, timeout;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_sel, m_last, m_cnt;
  bit   m_busy, m_to;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel = 0;
    m_last = 7;
    m_cnt = 0;
    m_to = 1'b0;
  endtask

  task automatic model_next(input logic [7:0] r);
    bit to;
    int pick, i;
    exp_t e;
    to = TO_EN && m_busy && r[m_sel] && m_cnt == MH - 1 && (r & ~(8'd1 << m_sel)) != 8'd0;
    if (!m_busy || !r[m_sel] || to) begin
      pick = -1;
      for (int k = 1; k <= 8; k++) begin
        i = (m_last + k) % 8;
        if (pick < 0 && r[i] && !(to && i == m_sel)) pick = i;
      end
      m_cnt = 0;
      if (pick >= 0) begin
        m_busy = 1'b1;
        m_sel = pick;
        m_last = pick;
      end else m_busy = 1'b0;
    end else m_cnt = (m_cnt == MH - 1) ? 0 : m_cnt + 1;
    m_to = to;
    e.g = m_busy ? 8'd1 << m_sel : 8'h00;
    e.s = 3'(m_sel);
    e.b = m_busy;
    e.t = m_to;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    req = r;
    model_next(r);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt", gnt, e.g);
    check("sel", {5'b0, sel}, {5'b0, e.s});
    check("busy", {7'b0, busy}, {7'b0, e.b});
    check("timeout", {7'b0, timeout}, {7'b0, e.t});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    model_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
      check("rst_gnt", gnt, 8'h00);
      check("rst_sel", {5'b0, sel}, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;

    step(8'h04);
    check("b2_gnt", gnt, 8'h04);
    check("b2_sel", {5'b0, sel}, 8'h02);
    repeat (10) step(8'h04);
    check("b2_hold", gnt, 8'h04);
    step(8'h00);
    check("rel_busy", {7'b0, busy}, 8'h00);
    check("rel_sel", {5'b0, sel}, 8'h02);

    step(8'h04);
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 8'h00;
    #1;
    check("arst_gnt", gnt, 8'h00);
    check("arst_sel", {5'b0, sel}, 8'h00);
    check("arst_busy", {7'b0, busy}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    step(8'hFF);
    check("ff_first", gnt, 8'h01);
    step(8'hFE);
    check("ff_next1", gnt, 8'h02);
    step(8'hFC);
    check("ff_next2", gnt, 8'h04);
    step(8'h05);
    step(8'h01);
    check("wrap_gnt", gnt, 8'h01);
    check("wrap_sel", {5'b0, sel}, 8'h00);

    r = 8'h00;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) r = r & ~gnt;
      step(r);
    end

    do_reset();
    repeat (12) step(8'h03);
    step(8'h00);

    do_reset();
    repeat (20) begin
      step(8'h08);
      check("solo_gnt", gnt, 8'h08);
      check("solo_to", {7'b0, timeout}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
